// File: rtl/csdf_split.sv
// Cyclo-static split actor: pops one tagged token and replays its payload NUM_OP times
// to every port of the flux selected by the tag, all-or-nothing per firing.
module csdf_split #(
    parameter  int DATA_WIDTH = 8,
    parameter  int FLUX       = 2,
    parameter  int PORTS      = 2,
    parameter  int NUM_OP     = 4,
    localparam int TAG_WIDTH  = $clog2(FLUX),
    localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH,
    localparam int CNT_W      = (NUM_OP > 1) ? $clog2(NUM_OP) : 1,
    localparam int LANES      = FLUX * PORTS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_empty,
    input  logic [WIDTH-1:0]            in_dout,
    output logic                        in_read,
    input  logic [LANES-1:0]            out_full,
    output logic [LANES-1:0]            out_write,
    output logic [LANES*DATA_WIDTH-1:0] out_din,
    output logic                        busy,
    output logic                        drop
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                state_reg, state_next;
    logic [TAG_WIDTH-1:0]  h_tag_reg, h_tag_next;
    logic [DATA_WIDTH-1:0] h_data_reg, h_data_next;
    logic [CNT_W-1:0]      h_cnt_reg, h_cnt_next;
    logic                  drop_reg, drop_next;

    logic                  h_vld;
    logic [LANES-1:0]      lane_hit;
    logic                  blocked;
    logic                  fire;
    logic                  last;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  tag_ok;

    assign h_vld  = (state_reg == EMIT);
    assign in_tag = in_dout[WIDTH-1:DATA_WIDTH];
    // One extra bit so the comparison also works when FLUX is a power of two.
    assign tag_ok = ({1'b0, in_tag} < (TAG_WIDTH+1)'(FLUX));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_hit[gi]                          = (h_tag_reg == TAG_WIDTH'(gi / PORTS));
            assign out_write[gi]                         = fire & lane_hit[gi];
            assign out_din[gi*DATA_WIDTH +: DATA_WIDTH]  = lane_hit[gi] ? h_data_reg : '0;
        end
    endgenerate

    // Only the held flux's full flags matter; other fluxes never stall us.
    assign blocked = |(out_full & lane_hit);
    assign fire    = h_vld & ~blocked;
    assign last    = fire & (h_cnt_reg == '0);
    assign in_read = ~rst & ~in_empty & (~h_vld | last);
    assign busy    = h_vld;
    assign drop    = drop_reg;

    always_comb begin
        state_next  = state_reg;
        h_tag_next  = h_tag_reg;
        h_data_next = h_data_reg;
        h_cnt_next  = h_cnt_reg;
        drop_next   = 1'b0;
        if (in_read) begin
            if (tag_ok) begin
                state_next  = EMIT;
                h_tag_next  = in_tag;
                h_data_next = in_dout[DATA_WIDTH-1:0];
                h_cnt_next  = CNT_W'(NUM_OP - 1);
            end else begin
                state_next = IDLE;
                drop_next  = 1'b1;
            end
        end else if (fire) begin
            if (last) begin
                state_next = IDLE;
            end else begin
                h_cnt_next = h_cnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            h_tag_reg  <= '0;
            h_data_reg <= '0;
            h_cnt_reg  <= '0;
            drop_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            h_tag_reg  <= h_tag_next;
            h_data_reg <= h_data_next;
            h_cnt_reg  <= h_cnt_next;
            drop_reg   <= drop_next;
        end
    end

endmodule

// File: tb/tb_csdf_split.sv
// Directed bench for csdf_split: default config, FLUX=3 (illegal tag) and NUM_OP=1 instances.
module tb_csdf_split;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Default instance: FLUX=2, PORTS=2, NUM_OP=4
    logic        d0_in_empty = 1'b1;
    logic [8:0]  d0_in_dout  = '0;
    logic        d0_in_read;
    logic [3:0]  d0_out_full = '0;
    logic [3:0]  d0_out_write;
    logic [31:0] d0_out_din;
    logic        d0_busy, d0_drop;

    // FLUX=3 instance
    logic        d3_in_empty = 1'b1;
    logic [9:0]  d3_in_dout  = '0;
    logic        d3_in_read;
    logic [5:0]  d3_out_full = '0;
    logic [5:0]  d3_out_write;
    logic [47:0] d3_out_din;
    logic        d3_busy, d3_drop;

    // NUM_OP=1 instance
    logic        d1_in_empty = 1'b1;
    logic [8:0]  d1_in_dout  = '0;
    logic        d1_in_read;
    logic [3:0]  d1_out_full = '0;
    logic [3:0]  d1_out_write;
    logic [31:0] d1_out_din;
    logic        d1_busy, d1_drop;

    csdf_split #(.DATA_WIDTH(8), .FLUX(2), .PORTS(2), .NUM_OP(4)) u_dut (
        .clk(clk), .rst(rst), .in_empty(d0_in_empty), .in_dout(d0_in_dout),
        .in_read(d0_in_read), .out_full(d0_out_full), .out_write(d0_out_write),
        .out_din(d0_out_din), .busy(d0_busy), .drop(d0_drop));

    csdf_split #(.DATA_WIDTH(8), .FLUX(3), .PORTS(2), .NUM_OP(4)) u_dut3 (
        .clk(clk), .rst(rst), .in_empty(d3_in_empty), .in_dout(d3_in_dout),
        .in_read(d3_in_read), .out_full(d3_out_full), .out_write(d3_out_write),
        .out_din(d3_out_din), .busy(d3_busy), .drop(d3_drop));

    csdf_split #(.DATA_WIDTH(8), .FLUX(2), .PORTS(2), .NUM_OP(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_empty(d1_in_empty), .in_dout(d1_in_dout),
        .in_read(d1_in_read), .out_full(d1_out_full), .out_write(d1_out_write),
        .out_din(d1_out_din), .busy(d1_busy), .drop(d1_drop));

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d0_in_empty = 1'b0; d0_in_dout = {1'b1, 8'hAB};
        repeat (2) begin
            cyc(); #1;
            total++;
            if (d0_in_read !== 1'b0) begin
                bad++; $display("FAIL reset_in_read: got %b want 0", d0_in_read);
            end
        end
        cyc(); rst = 1'b0; d0_in_empty = 1'b1; #1;
        total++;
        if (d0_busy !== 1'b0 || d0_out_write !== 4'b0 || d0_out_din !== 32'h0 || d0_drop !== 1'b0) begin
            bad++; $display("FAIL reset_d0: busy=%b wr=%b din=%h drop=%b want 0/0/0/0", d0_busy, d0_out_write, d0_out_din, d0_drop);
        end
        total++;
        if (d3_busy !== 1'b0 || d3_out_write !== 6'b0 || d3_out_din !== 48'h0 || d3_drop !== 1'b0) begin
            bad++; $display("FAIL reset_d3: busy=%b wr=%b din=%h drop=%b want 0/0/0/0", d3_busy, d3_out_write, d3_out_din, d3_drop);
        end
        total++;
        if (d1_busy !== 1'b0 || d1_out_write !== 4'b0 || d1_in_read !== 1'b0) begin
            bad++; $display("FAIL reset_d1: busy=%b wr=%b rd=%b want 0/0/0", d1_busy, d1_out_write, d1_in_read);
        end
        $display("reset: done");
    endtask

    task automatic test_single();
        cyc(); d0_in_empty = 1'b0; d0_in_dout = {1'b1, 8'h5A}; #1;
        total++;
        if (d0_in_read !== 1'b1 || d0_out_write !== 4'b0) begin
            bad++; $display("FAIL single_pop: rd=%b wr=%b want 1/0000", d0_in_read, d0_out_write);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(); d0_in_empty = 1'b1; #1;
            total++;
            if (d0_out_write !== 4'b1100 || d0_out_din !== 32'h5A5A_0000 || d0_busy !== 1'b1) begin
                bad++; $display("FAIL single_fire%0d: wr=%b din=%h busy=%b want 1100/5a5a0000/1", i, d0_out_write, d0_out_din, d0_busy);
            end
        end
        cyc(); #1;
        total++;
        if (d0_out_write !== 4'b0 || d0_busy !== 1'b0) begin
            bad++; $display("FAIL single_end: wr=%b busy=%b want 0000/0", d0_out_write, d0_busy);
        end
        $display("single: token {1,5a} emitted");
    endtask

    task automatic test_back_to_back();
        cyc(); d0_in_empty = 1'b0; d0_in_dout = {1'b0, 8'h11}; #1;
        total++;
        if (d0_in_read !== 1'b1) begin
            bad++; $display("FAIL b2b_pop0: rd=%b want 1", d0_in_read);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(); d0_in_dout = {1'b1, 8'h22}; #1;
            total++;
            if (d0_out_write !== 4'b0011 || d0_out_din !== 32'h0000_1111 || d0_in_read !== (i == 3)) begin
                bad++; $display("FAIL b2b_f0_%0d: wr=%b din=%h rd=%b want 0011/00001111/%0d", i, d0_out_write, d0_out_din, d0_in_read, (i == 3));
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(); d0_in_empty = 1'b1; #1;
            total++;
            if (d0_out_write !== 4'b1100 || d0_out_din !== 32'h2222_0000) begin
                bad++; $display("FAIL b2b_f1_%0d: wr=%b din=%h want 1100/22220000", i, d0_out_write, d0_out_din);
            end
        end
        cyc(); #1;
        total++;
        if (d0_out_write !== 4'b0 || d0_busy !== 1'b0) begin
            bad++; $display("FAIL b2b_end: wr=%b busy=%b want 0000/0", d0_out_write, d0_busy);
        end
        $display("back_to_back: tokens {0,11},{1,22} emitted");
    endtask

    task automatic test_backpressure();
        logic [3:0] full_pat [0:7];
        logic [3:0] want_wr  [0:7];
        full_pat = '{4'b1100, 4'b0100, 4'b0010, 4'b1010, 4'b0110, 4'b1000, 4'b0000, 4'b0000};
        want_wr  = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0011, 4'b0000};
        cyc(); d0_in_empty = 1'b0; d0_in_dout = {1'b0, 8'h33}; #1;
        total++;
        if (d0_in_read !== 1'b1) begin
            bad++; $display("FAIL bp_pop: rd=%b want 1", d0_in_read);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            d0_out_full = full_pat[i];
            // Offer a token during the stall: it must not be popped.
            d0_in_empty = !(i >= 2 && i <= 4);
            d0_in_dout  = {1'b1, 8'hEE};
            #1;
            total++;
            if (d0_out_write !== want_wr[i] || d0_in_read !== 1'b0 || d0_busy !== (i < 7)) begin
                bad++; $display("FAIL bp_cyc%0d: wr=%b rd=%b busy=%b want %b/0/%0d", i, d0_out_write, d0_in_read, d0_busy, want_wr[i], (i < 7));
            end
        end
        d0_in_empty = 1'b1; d0_out_full = '0;
        $display("backpressure: token {0,33} stalled 3 cycles");
    endtask

    task automatic test_reset_mid();
        cyc(); d0_in_empty = 1'b0; d0_in_dout = {1'b1, 8'h44}; #1;
        for (int i = 0; i < 2; i++) begin
            cyc(); d0_in_empty = 1'b1; #1;
            total++;
            if (d0_out_write !== 4'b1100) begin
                bad++; $display("FAIL rmid_fire%0d: wr=%b want 1100", i, d0_out_write);
            end
        end
        cyc(); rst = 1'b1; d0_in_empty = 1'b0; d0_in_dout = {1'b0, 8'h99}; #1;
        total++;
        if (d0_in_read !== 1'b0) begin
            bad++; $display("FAIL rmid_rd: rd=%b want 0", d0_in_read);
        end
        cyc(); rst = 1'b0; d0_in_empty = 1'b1; #1;
        total++;
        if (d0_out_write !== 4'b0 || d0_busy !== 1'b0 || d0_out_din !== 32'h0) begin
            bad++; $display("FAIL rmid_after: wr=%b busy=%b din=%h want 0000/0/0", d0_out_write, d0_busy, d0_out_din);
        end
        cyc(); d0_in_empty = 1'b0; d0_in_dout = {1'b0, 8'h55}; #1;
        for (int i = 0; i < 5; i++) begin
            cyc(); d0_in_empty = 1'b1; #1;
            total++;
            if (d0_out_write !== ((i < 4) ? 4'b0011 : 4'b0000) || (i < 4 && d0_out_din !== 32'h0000_5555)) begin
                bad++; $display("FAIL rmid_next%0d: wr=%b din=%h want %b/00005555", i, d0_out_write, d0_out_din, (i < 4) ? 4'b0011 : 4'b0000);
            end
        end
        $display("reset_mid: token {1,44} abandoned, {0,55} emitted");
    endtask

    task automatic test_illegal_tag();
        cyc(); d3_in_empty = 1'b0; d3_in_dout = {2'd3, 8'h66}; #1;
        total++;
        if (d3_in_read !== 1'b1 || d3_drop !== 1'b0) begin
            bad++; $display("FAIL ill_pop: rd=%b drop=%b want 1/0", d3_in_read, d3_drop);
        end
        cyc(); d3_in_empty = 1'b1; #1;
        total++;
        if (d3_drop !== 1'b1 || d3_out_write !== 6'b0 || d3_busy !== 1'b0) begin
            bad++; $display("FAIL ill_drop: drop=%b wr=%b busy=%b want 1/000000/0", d3_drop, d3_out_write, d3_busy);
        end
        cyc(); d3_in_empty = 1'b0; d3_in_dout = {2'd2, 8'h77}; #1;
        total++;
        if (d3_drop !== 1'b0 || d3_in_read !== 1'b1) begin
            bad++; $display("FAIL ill_next_pop: drop=%b rd=%b want 0/1", d3_drop, d3_in_read);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(); d3_in_empty = 1'b1; #1;
            total++;
            if (d3_out_write !== ((i < 4) ? 6'b110000 : 6'b000000) || d3_out_din !== 48'h7777_0000_0000) begin
                bad++; $display("FAIL ill_fire%0d: wr=%b din=%h want %b/777700000000", i, d3_out_write, d3_out_din, (i < 4) ? 6'b110000 : 6'b000000);
            end
        end
        $display("illegal_tag: {3,66} dropped, {2,77} emitted");
    endtask

    task automatic test_num_op1();
        for (int i = 0; i < 6; i++) begin
            cyc();
            d1_in_empty = (i == 5);
            d1_in_dout  = {1'b0, 8'(8'h10 + i)};
            #1;
            total++;
            if (d1_in_read !== (i < 5)) begin
                bad++; $display("FAIL op1_rd%0d: rd=%b want %0d", i, d1_in_read, (i < 5));
            end
            if (i > 0) begin
                total++;
                if (d1_out_write !== 4'b0011 || d1_out_din !== {16'h0, {2{8'(8'h10 + i - 1)}}}) begin
                    bad++; $display("FAIL op1_fire%0d: wr=%b din=%h want 0011/data %h", i, d1_out_write, d1_out_din, 8'(8'h10 + i - 1));
                end
            end
        end
        cyc(); #1;
        total++;
        if (d1_out_write !== 4'b0 || d1_busy !== 1'b0) begin
            bad++; $display("FAIL op1_end: wr=%b busy=%b want 0000/0", d1_out_write, d1_busy);
        end
        $display("num_op1: 5 tokens streamed");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_illegal_tag();
        test_num_op1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csdf_split.md
CSDF_SPLIT -- requirements
Module: csdf_split

Interface
REQ-001 The module SHALL have the parameter DATA_WIDTH, default 8, giving the payload width in bits.
REQ-002 The module SHALL have the parameter FLUX, default 2, giving the number of tagged fluxes (legal range 2..16).
REQ-003 The module SHALL have the parameter PORTS, default 2, giving the output ports per flux.
REQ-004 The module SHALL have the parameter NUM_OP, default 4, giving the output firings per input token (legal range 1..256).
REQ-005 The module SHALL use the derived widths TAG_WIDTH=$clog2(FLUX), WIDTH=DATA_WIDTH+TAG_WIDTH and CNT_W=max(1,$clog2(NUM_OP)).
REQ-006 Port clk: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-007 Port rst: input, 1 bit, reset; rst is synchronous and active-high.
REQ-008 Port in_empty: input, 1 bit, upstream FIFO empty flag.
REQ-009 Port in_dout: input, WIDTH bits, upstream FIFO head word {tag[WIDTH-1:DATA_WIDTH], data[DATA_WIDTH-1:0]}.
REQ-010 Port in_read: output, 1 bit, pop strobe to the upstream FIFO.
REQ-011 Port out_full: input, FLUX*PORTS bits, downstream FIFO full flags; bit p+f*PORTS belongs to flux f, port p.
REQ-012 Port out_write: output, FLUX*PORTS bits, downstream push strobes, using the out_full bit order.
REQ-013 Port out_din: output, FLUX*PORTS*DATA_WIDTH bits, downstream data; lane p+f*PORTS occupies bits [(p+f*PORTS)*DATA_WIDTH +: DATA_WIDTH].
REQ-014 Port busy: output, 1 bit, high while a token is held.
REQ-015 Port drop: output, 1 bit, one-cycle pulse when a token with an illegal tag is discarded.

Function
REQ-016 The module SHALL contain a one-token holding register (h_tag, h_data), a down-counter h_cnt of CNT_W bits, and a valid bit h_vld (state IDLE when h_vld=0, EMIT when h_vld=1).
REQ-017 blocked SHALL be defined as the OR of out_full[p+h_tag*PORTS] over all p.
REQ-018 fire SHALL be defined as h_vld & ~blocked.
REQ-019 fire SHALL assert out_write[p+h_tag*PORTS] for every p in the same cycle, and SHALL assert no other out_write bit (all-or-nothing per flux; no partial firings).
REQ-020 out_din SHALL carry h_data on every lane of flux h_tag and zero on all other lanes, regardless of fire.
REQ-021 last SHALL be defined as fire & (h_cnt==0).
REQ-022 in_read SHALL be combinational: ~in_empty & (~h_vld | last), giving back-to-back tokens with no bubble.
REQ-023 On in_read, if tag<FLUX, the module SHALL load h_tag/h_data from in_dout, set h_cnt=NUM_OP-1 and set h_vld=1.
REQ-024 On in_read, if tag>=FLUX (possible only for non-power-of-2 FLUX), the module SHALL consume and discard the token, pulse drop for one cycle in the following cycle, and leave h_vld=0.
REQ-025 On fire with h_cnt!=0, h_cnt SHALL decrement by 1.
REQ-026 On last without a simultaneous load, h_vld SHALL clear.
REQ-027 A token popped at edge t SHALL produce its first write in cycle t+1 if its flux is unblocked; each token SHALL produce exactly NUM_OP firings.
REQ-028 With NUM_OP=1, every fire SHALL be last.
REQ-029 While blocked, h_cnt, h_data and h_tag SHALL hold and in_read SHALL stay 0 (head-of-line blocking across fluxes is intended).
REQ-030 Full flags of fluxes other than h_tag SHALL be ignored.
REQ-031 busy SHALL equal h_vld.

Reset
REQ-032 When rst=1 at a clock edge, h_vld, h_cnt, h_tag, h_data and drop SHALL clear to 0, and in_read SHALL be forced to 0 during the rst cycle.
REQ-033 Reset mid-emission SHALL abandon the held token without further writes; the firings already issued are not replayed.
REQ-034 After reset, out_write SHALL be all 0, out_din all 0 and busy=0 until a token is read.

Verification (FLUX=2, PORTS=2, NUM_OP=4, DATA_WIDTH=8)
REQ-035 Scenario 1: single token {1,0x5A}, no full -> in_read for 1 cycle, then out_write=4'b1100 for 4 consecutive cycles with lanes 2,3=0x5A, then busy=0.
REQ-036 Scenario 2: tokens {0,0x11},{1,0x22} back-to-back -> 4 firings of 4'b0011, immediately followed by 4 firings of 4'b1100 with no idle cycle; in_read high on the cycle of the 4th flux-0 firing.
REQ-037 Scenario 3: token {0,0x33}, out_full[1] raised after 2 firings for 3 cycles -> no writes during those 3 cycles, h_cnt held, then the remaining 2 firings occur; out_full[3:2] toggling has no effect.
REQ-038 Scenario 4: rst asserted after 2 firings of {1,0x44} -> out_write=0 and busy=0 from the next cycle; the next token {0,0x55} yields exactly 4 firings.
REQ-039 Scenario 5: FLUX=3, token {3,0x66} -> token popped, drop pulses once, no out_write; the following token {2,0x77} fires 4 times on lanes 4,5.
REQ-040 Scenario 6: NUM_OP=1, stream of 5 flux-0 tokens with in_empty=0 -> in_read high for 5 consecutive cycles and 5 consecutive single firings.
